// File: rtl/pocq_sched.sv
// Point-of-coherence queue: per-entry sleep/wake/issue state with strict
// allocation-age selection of the oldest READY entry.
module pocq_sched #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TXNID_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [TXNID_W-1:0]         alloc_txnid,
    input  logic [WIDTH-1:0]           alloc_data,
    input  logic                       alloc_sleep,
    output logic                       alloc_err,
    input  logic                       release_valid,
    input  logic [TXNID_W-1:0]         release_txnid,
    input  logic                       sleep_valid,
    input  logic [TXNID_W-1:0]         sleep_txnid,
    input  logic                       wake_valid,
    input  logic [TXNID_W-1:0]         wake_txnid,
    input  logic                       wake_all,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TXNID_W-1:0]         out_txnid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH)-1:0]   out_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_READY  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_ISSUED = 2'd3
    } ent_st_e;

    ent_st_e            st_q    [DEPTH];
    ent_st_e            st_d    [DEPTH];
    logic [TXNID_W-1:0] tid_q   [DEPTH];
    logic [TXNID_W-1:0] tid_d   [DEPTH];
    logic [WIDTH-1:0]   data_q  [DEPTH];
    logic [WIDTH-1:0]   data_d  [DEPTH];
    // older_q[i][j] = 1 when entry i was allocated before entry j
    logic [DEPTH-1:0]   older_q [DEPTH];
    logic [DEPTH-1:0]   older_d [DEPTH];

    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               alloc_err_q, alloc_err_d;

    logic [IDX_W-1:0]   a_idx, r_idx, s_idx, w_idx, sel_idx;
    logic [DEPTH-1:0]   ready_vec;
    logic [DEPTH-1:0]   self_m;
    logic               sel_found;
    logic               alloc_ok, rel_hit, sleep_hit, wake_hit, issue;

    assign a_idx = alloc_txnid[IDX_W-1:0];
    assign r_idx = release_txnid[IDX_W-1:0];
    assign s_idx = sleep_txnid[IDX_W-1:0];
    assign w_idx = wake_txnid[IDX_W-1:0];

    // Oldest READY entry: READY and older than every other READY entry
    always_comb begin
        ready_vec = '0;
        self_m    = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (st_q[i] == ST_READY);
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            self_m    = '0;
            self_m[i] = 1'b1;
            if (ready_vec[i] && ((older_q[i] | ~ready_vec | self_m) == '1)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign out_valid = sel_found;
    assign out_idx   = sel_idx;
    assign out_txnid = sel_found ? tid_q[sel_idx]  : '0;
    assign out_data  = sel_found ? data_q[sel_idx] : '0;

    // Command qualification against the pre-edge entry state
    always_comb begin
        alloc_ok  = alloc_valid && (st_q[a_idx] == ST_FREE);
        rel_hit   = release_valid && (st_q[r_idx] != ST_FREE) && (tid_q[r_idx] == release_txnid);
        sleep_hit = sleep_valid && (st_q[s_idx] != ST_FREE) && (tid_q[s_idx] == sleep_txnid);
        wake_hit  = wake_valid && (st_q[w_idx] != ST_FREE) && (tid_q[w_idx] == wake_txnid);
        issue     = sel_found && out_ready;
    end

    // Entry next state; later assignments carry higher priority
    always_comb begin
        st_d        = st_q;
        tid_d       = tid_q;
        data_d      = data_q;
        older_d     = older_q;
        alloc_err_d = alloc_valid && !alloc_ok;
        count_d     = count_q + CNT_W'(alloc_ok) - CNT_W'(rel_hit);
        full_d      = (count_d == CNT_W'(DEPTH));
        empty_d     = (count_d == '0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alloc_ok && (a_idx == IDX_W'(i))) begin
                st_d[i]   = alloc_sleep ? ST_SLEEP : ST_READY;
                tid_d[i]  = alloc_txnid;
                data_d[i] = alloc_data;
            end
            if (alloc_ok) begin
                if (a_idx == IDX_W'(i)) begin
                    older_d[i] = '0;
                end else begin
                    older_d[i][a_idx] = 1'b1;
                end
            end
            if (issue && (sel_idx == IDX_W'(i))) begin
                st_d[i] = ST_ISSUED;
            end
            if ((st_q[i] == ST_SLEEP) && (wake_all || (wake_hit && (w_idx == IDX_W'(i))))) begin
                st_d[i] = ST_READY;
            end
            if (sleep_hit && (s_idx == IDX_W'(i)) &&
                ((st_q[i] == ST_READY) || (st_q[i] == ST_ISSUED))) begin
                st_d[i] = ST_SLEEP;
            end
            if (rel_hit && (r_idx == IDX_W'(i))) begin
                st_d[i] = ST_FREE;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st_q[i]    <= ST_FREE;
                tid_q[i]   <= '0;
                data_q[i]  <= '0;
                older_q[i] <= '0;
            end
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alloc_err_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            tid_q       <= tid_d;
            data_q      <= data_d;
            older_q     <= older_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alloc_err_q <= alloc_err_d;
        end
    end

    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign alloc_err = alloc_err_q;

endmodule
